// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and captures the returned word with its PC into the IF/ID register.
//
// state | meaning
// IDLE  | waiting for start; PC parked at RESET_PC, IF/ID holds a bubble
// RUN   | fetching; handles redirect, stall and out-of-range drain
// HALT  | fetch permanently stopped until reset
module if_fetch_stage #(
  parameter int                    PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
  parameter logic [PC_WIDTH-1:0]   PROG_END     = PC_WIDTH'(148),
  parameter int                    DRAIN_CYCLES = 3,
  parameter logic [31:0]           NOP_INST     = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                pc_src,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] Inst_Address,
  input  logic [31:0]         Instruction,
  output logic [PC_WIDTH-1:0] IF_ID_PC,
  output logic [31:0]         IF_ID_Instruction,
  output logic                IF_ID_Valid,
  output logic                halted
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic [PC_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]         if_id_inst_q, if_id_inst_d;
  logic                if_id_valid_q, if_id_valid_d;

  // State, PC, drain counter and IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drain_cnt_q   <= '0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_cnt_q   <= drain_cnt_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Next-state: redirect beats stall beats drain beats normal fetch
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_cnt_d   = drain_cnt_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (pc_src) begin
          // misaligned targets are silently word-aligned
          pc_d          = {branch_target[PC_WIDTH-1:2], 2'b00};
          if_id_pc_d    = '0;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
          drain_cnt_d   = '0;
        end else if (stall) begin
          // hold everything
        end else if (pc_q >= PROG_END) begin
          // keep draining so a late branch can still pull us back
          if_id_pc_d    = '0;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
          drain_cnt_d   = drain_cnt_q + CNT_W'(1);
          if (drain_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = HALT;
        end else begin
          if_id_pc_d    = pc_q;
          if_id_inst_d  = Instruction;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + PC_WIDTH'(4);
          drain_cnt_d   = '0;
        end
      end
      HALT: begin
        // sticky; IF/ID already holds the bubble from the last drain cycle
      end
      default: state_d = IDLE;
    endcase
  end

  assign Inst_Address      = pc_q;
  assign IF_ID_PC          = if_id_pc_q;
  assign IF_ID_Instruction = if_id_inst_q;
  assign IF_ID_Valid       = if_id_valid_q;
  assign halted            = (state_q == HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small combinational instruction ROM.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        pc_src;
  logic [63:0] branch_target;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        halted;

  int errors = 0;
  int checks = 0;

  if_fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .stall             (stall),
    .pc_src            (pc_src),
    .branch_target     (branch_target),
    .Inst_Address      (inst_address),
    .Instruction       (instruction),
    .IF_ID_PC          (if_id_pc),
    .IF_ID_Instruction (if_id_instruction),
    .IF_ID_Valid       (if_id_valid),
    .halted            (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory contents
  function automatic logic [31:0] rom(input logic [63:0] a);
    case (a)
      64'd0:   rom = 32'h0060_0593;
      64'd12:  rom = 32'h0000_0F13;
      64'd16:  rom = 32'h0060_0E13;
      64'd20:  rom = 32'h10BF_2023;
      64'd104: rom = 32'h001F_0F13;
      default: rom = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign instruction = rom(inst_address);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [63:0] pc,
                            input logic [31:0] ins, input logic v);
    check_eq({tag, "_pc"},    if_id_pc, pc);
    check_eq({tag, "_inst"},  64'(if_id_instruction), 64'(ins));
    check_eq({tag, "_valid"}, 64'(if_id_valid), 64'(v));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; pc_src = 1'b0; branch_target = '0;
    step(); step();
    check_eq("rst_addr", inst_address, 64'd0);
    check_ifid("rst", 64'd0, NOP, 1'b0);
    check_eq("rst_halted", 64'(halted), 64'd0);

    // release, stay idle, then start
    reset = 1'b1;
    stall = 1'b1; pc_src = 1'b1; branch_target = 64'd80;
    step();
    check_eq("idle_addr", inst_address, 64'd0);
    check_eq("idle_valid", 64'(if_id_valid), 64'd0);
    stall = 1'b0; pc_src = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_addr0", inst_address, 64'd0);
    check_eq("start_valid0", 64'(if_id_valid), 64'd0);
    step();
    check_eq("run_addr4", inst_address, 64'd4);
    check_ifid("first", 64'd0, 32'h0060_0593, 1'b1);
    step();
    check_eq("run_addr8", inst_address, 64'd8);
    check_eq("second_pc", if_id_pc, 64'd4);
    step(); step();
    check_eq("pre_stall_addr", inst_address, 64'd16);
    check_ifid("pre_stall", 64'd12, 32'h0000_0F13, 1'b1);

    // stall for two cycles at PC=16
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("stall_addr", inst_address, 64'd16);
      check_ifid("stall_hold", 64'd12, 32'h0000_0F13, 1'b1);
    end
    stall = 1'b0;
    step();
    check_ifid("post_stall", 64'd16, 32'h0060_0E13, 1'b1);
    check_eq("post_stall_addr", inst_address, 64'd20);

    // redirect together with stall, misaligned target
    for (int i = 0; i < 6; i++) step();
    check_eq("at44", inst_address, 64'd44);
    pc_src = 1'b1; stall = 1'b1; branch_target = 64'h16;
    step();
    pc_src = 1'b0; stall = 1'b0;
    check_eq("redir_addr", inst_address, 64'h14);
    check_ifid("redir_bubble", 64'd0, NOP, 1'b0);
    step();
    check_ifid("redir_cap", 64'h14, 32'h10BF_2023, 1'b1);
    check_eq("redir_next", inst_address, 64'h18);

    // run to end of program, redirect on the 2nd drain cycle
    for (int i = 0; i < 31; i++) step();
    check_eq("end_addr", inst_address, 64'd148);
    check_ifid("last_cap", 64'd144, 32'hC0DE_0090, 1'b1);
    step();
    check_ifid("drain1", 64'd0, NOP, 1'b0);
    check_eq("drain1_addr", inst_address, 64'd148);
    pc_src = 1'b1; branch_target = 64'd104;
    step();
    pc_src = 1'b0;
    check_eq("drain_redir_addr", inst_address, 64'd104);
    check_eq("drain_redir_halted", 64'(halted), 64'd0);
    step();
    check_ifid("drain_redir_cap", 64'd104, 32'h001F_0F13, 1'b1);
    check_eq("drain_redir_next", inst_address, 64'd108);

    // full drain into HALT
    for (int i = 0; i < 10; i++) step();
    check_eq("end2_addr", inst_address, 64'd148);
    step();
    check_eq("halt_d1", 64'(halted), 64'd0);
    check_eq("halt_d1_valid", 64'(if_id_valid), 64'd0);
    step();
    check_eq("halt_d2", 64'(halted), 64'd0);
    step();
    check_eq("halt_d3", 64'(halted), 64'd1);
    check_eq("halt_addr", inst_address, 64'd148);
    check_eq("halt_valid", 64'(if_id_valid), 64'd0);
    start = 1'b1; pc_src = 1'b1; branch_target = 64'd0;
    step();
    start = 1'b0; pc_src = 1'b0;
    step();
    check_eq("halt_sticky", 64'(halted), 64'd1);
    check_eq("halt_sticky_addr", inst_address, 64'd148);
    check_ifid("halt_sticky", 64'd0, NOP, 1'b0);

    // async reset out of HALT, restart, then async reset mid-run
    #2 reset = 1'b0;
    #1;
    check_eq("areset_halted", 64'(halted), 64'd0);
    check_eq("areset_addr0", inst_address, 64'd0);
    #1 reset = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_ifid("restart", 64'd0, 32'h0060_0593, 1'b1);
    #3 reset = 1'b0;
    #1;
    check_eq("midrst_addr", inst_address, 64'd0);
    check_ifid("midrst", 64'd0, NOP, 1'b0);
    check_eq("midrst_halted", 64'(halted), 64'd0);
    #1 reset = 1'b1;
    step(); step();
    check_eq("post_rst_idle_addr", inst_address, 64'd0);
    check_eq("post_rst_idle_valid", 64'(if_id_valid), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_ifid("post_rst_run", 64'd0, 32'h0060_0593, 1'b1);
    check_eq("post_rst_addr", inst_address, 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
